// File: rtl/four_digit_led_scan_decoder.sv
// Receive-side monitor for a multiplexed four-digit seven-segment bus: samples the lines,
// captures each digit once its drive has settled, and emits decoded 4-character frames.
module four_digit_led_scan_decoder #(
   parameter int unsigned SETTLE  = 4,
   parameter int unsigned TIMEOUT = 65536
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        an3,
   input  logic        an2,
   input  logic        an1,
   input  logic        an0,
   input  logic        a,
   input  logic        b,
   input  logic        c,
   input  logic        d,
   input  logic        e,
   input  logic        f,
   input  logic        g,
   input  logic        dp,
   output logic [19:0] frame,
   output logic [3:0]  frame_dp,
   output logic        frame_valid,
   output logic        frame_changed,
   output logic        err_multi,
   output logic        stalled
);

   localparam int unsigned SW = 12;
   localparam int unsigned CW = 8;
   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CAP_CNT = CW'(SETTLE - 1);
   localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);

   function automatic logic [4:0] seg_decode(input logic [6:0] i_pat);
      logic [4:0] v_code;
      case (i_pat)
         7'b1111110: v_code = 5'h00;
         7'b0110000: v_code = 5'h01;
         7'b1101101: v_code = 5'h02;
         7'b1111001: v_code = 5'h03;
         7'b0110011: v_code = 5'h04;
         7'b1011011: v_code = 5'h05;
         7'b1011111: v_code = 5'h06;
         7'b1110000: v_code = 5'h07;
         7'b1111111: v_code = 5'h08;
         7'b1111011: v_code = 5'h09;
         7'b1110111: v_code = 5'h0A;
         7'b0011111: v_code = 5'h0B;
         7'b1001110: v_code = 5'h0C;
         7'b0111101: v_code = 5'h0D;
         7'b1001111: v_code = 5'h0E;
         7'b1000111: v_code = 5'h0F;
         7'b0000000: v_code = 5'h10;
         7'b0000001: v_code = 5'h11;
         default:    v_code = 5'h1F;
      endcase
      return v_code;
   endfunction

   logic [SW-1:0] r_s;
   logic [CW-1:0] r_cnt;
   logic          r_armed;
   logic [WW-1:0] r_wd;
   logic [4:0]    r_slot [4];
   logic [3:0]    r_slot_dp;
   logic [3:0]    r_slot_valid;
   logic          r_have_prev;

   logic [SW-1:0] w_in;
   logic [3:0]    w_act;
   logic [1:0]    w_idx;
   logic          w_one;
   logic          w_multi;
   logic          w_chg;
   logic          w_cap;
   logic          w_full;
   logic          w_wd_hit;
   logic          w_changed;
   logic [CW-1:0] w_cnt_nxt;
   logic [WW-1:0] w_wd_nxt;
   logic [4:0]    w_code;
   logic [3:0]    w_sel;
   logic [3:0]    w_valid_nxt;
   logic [3:0]    w_dp_nxt;
   logic [19:0]   w_frame_nxt;

   assign w_in   = {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};
   assign w_act  = ~w_in[11:8];
   assign w_chg  = (w_in != r_s);
   assign w_code = seg_decode(~w_in[7:1]);

   // One-hot anode decode; anything else is blank or a multi-drive error
   always_comb begin
      w_one = 1'b1;
      w_idx = 2'd0;
      case (w_act)
         4'b0001: w_idx = 2'd0;
         4'b0010: w_idx = 2'd1;
         4'b0100: w_idx = 2'd2;
         4'b1000: w_idx = 2'd3;
         default: w_one = 1'b0;
      endcase
   end

   assign w_multi   = (w_act != 4'b0000) && !w_one;
   assign w_cnt_nxt = (w_chg || w_multi) ? '0 :
                      ((r_cnt == '1) ? r_cnt : r_cnt + CW'(1));
   // Comparing the incoming sample with S makes the counter track S's stability directly
   assign w_cap     = !w_chg && r_armed && w_one && (w_cnt_nxt == CAP_CNT);

   assign w_sel       = 4'b0001 << w_idx;
   assign w_valid_nxt = r_slot_valid | w_sel;
   assign w_full      = w_cap && (w_valid_nxt == 4'b1111);

   always_comb begin
      w_frame_nxt = '0;
      w_dp_nxt    = r_slot_dp;
      for (int i = 0; i < 4; i++) begin
         w_frame_nxt[5*i +: 5] = w_sel[i] ? w_code : r_slot[i];
      end
      w_dp_nxt[w_idx] = ~w_in[0];
   end

   assign w_changed = !r_have_prev || ({w_frame_nxt, w_dp_nxt} != {frame, frame_dp});
   assign w_wd_nxt  = (r_wd == WD_MAX) ? r_wd : r_wd + WW'(1);
   assign w_wd_hit  = (w_wd_nxt == WD_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s       <= '1;
         r_cnt     <= '0;
         r_armed   <= 1'b1;
         err_multi <= 1'b0;
      end else begin
         r_s       <= w_in;
         r_cnt     <= w_cnt_nxt;
         err_multi <= w_multi;
         if (w_chg) begin
            r_armed <= 1'b1;
         end else if (w_cap) begin
            r_armed <= 1'b0;
         end
      end
   end

   // Slot assembly, frame emission and watchdog; a capture always beats watchdog expiry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            r_slot[i] <= '0;
         end
         r_slot_dp     <= '0;
         r_slot_valid  <= '0;
         r_have_prev   <= 1'b0;
         r_wd          <= '0;
         frame         <= {4{5'h10}};
         frame_dp      <= '0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         stalled       <= 1'b0;
      end else begin
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         if (w_cap) begin
            r_slot[w_idx]    <= w_code;
            r_slot_dp[w_idx] <= ~w_in[0];
            r_wd             <= '0;
            stalled          <= 1'b0;
            if (w_full) begin
               r_slot_valid  <= '0;
               frame         <= w_frame_nxt;
               frame_dp      <= w_dp_nxt;
               frame_valid   <= 1'b1;
               frame_changed <= w_changed;
               r_have_prev   <= 1'b1;
            end else begin
               r_slot_valid <= w_valid_nxt;
            end
         end else begin
            r_wd <= w_wd_nxt;
            if (w_wd_hit) begin
               stalled      <= 1'b1;
               r_slot_valid <= '0;
            end
         end
      end
   end

endmodule
